// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read at a time and holds the
// returned word for a valid/ready consumer, discarding responses that a redirect overtook.
module fetch_unit #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_en,
  input  logic [ADDR_WIDTH-1:0]  pc_in,
  output logic                   pc_inc,
  input  logic                   redirect,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_e;

  state_e                 r_state;
  state_e                 w_next_state;
  logic                   r_flush_pending;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [INSTR_WIDTH-1:0] r_instr_out;
  logic [ADDR_WIDTH-1:0]  r_instr_pc;

  logic w_load_addr;
  logic w_capture;
  logic w_set_flush;
  logic w_clr_flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_flush_pending <= 1'b0;
      r_addr          <= '0;
      r_instr_out     <= '0;
      r_instr_pc      <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load_addr) r_addr <= pc_in;
      if (w_capture) begin
        r_instr_out <= imem_rdata;
        r_instr_pc  <= r_addr;
      end
      if (w_clr_flush)      r_flush_pending <= 1'b0;
      else if (w_set_flush) r_flush_pending <= 1'b1;
    end
  end

  // NOTE: the default assignment at the top of each always_comb guarantees every
  // path assigns the signal, so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (fetch_en && !redirect) w_next_state = S_REQ;
      S_REQ: begin
        // A response overtaken by a redirect (now or earlier) is dropped.
        if (imem_ack) w_next_state = (redirect || r_flush_pending) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (redirect)         w_next_state = S_IDLE;
        else if (instr_ready) w_next_state = fetch_en ? S_REQ : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (r_state == S_REQ);
    instr_valid = (r_state == S_HOLD);
    w_capture   = imem_req && imem_ack && !redirect && !r_flush_pending;
    pc_inc      = w_capture;
    // The address is latched whenever a new request is about to start.
    w_load_addr = (w_next_state == S_REQ) && (r_state != S_REQ);
    w_set_flush = imem_req && redirect && !imem_ack;
    w_clr_flush = imem_req && imem_ack;
  end

  assign imem_addr = r_addr;
  assign instr_out = r_instr_out;
  assign instr_pc  = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_fetch_unit;

  localparam int AW = 12;
  localparam int IW = 16;

  logic          clk;
  logic          rst_n;
  logic          fetch_en;
  logic [AW-1:0] pc_in;
  logic          pc_inc;
  logic          redirect;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] instr_pc;

  int n_checks;
  int n_errors;

  fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .pc_in       (pc_in),
    .pc_inc      (pc_inc),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Applies one cycle of inputs at the falling edge and settles before returning.
  task automatic drive(input logic fe, input logic [AW-1:0] pc, input logic ack,
                       input logic [IW-1:0] rd, input logic redir, input logic rdy);
    @(negedge clk);
    fetch_en    = fe;
    pc_in       = pc;
    imem_ack    = ack;
    imem_rdata  = rd;
    redirect    = redir;
    instr_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_en = 1'b1; pc_in = 12'h3A5; imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    redirect = 1'b0; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_ctrl: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
    n_checks++;
    if ({imem_addr, instr_out, instr_pc} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: addr=%h out=%h pc=%h expected all zero", imem_addr, instr_out, instr_pc);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_release: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 12'h000, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL basic_idle: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
    drive(1'b0, 12'h000, 1'b1, 16'hA5C3, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, imem_addr} !== {3'b101, 12'h000}) begin
      n_errors++;
      $display("FAIL basic_req: req/valid/inc=%b addr=%h expected 101 addr 000",
               {imem_req, instr_valid, pc_inc}, imem_addr);
    end
    drive(1'b0, 12'h000, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, instr_out, instr_pc} !== {3'b010, 16'hA5C3, 12'h000}) begin
      n_errors++;
      $display("FAIL basic_hold: req/valid/inc=%b out=%h pc=%h expected 010 a5c3 000",
               {imem_req, instr_valid, pc_inc}, instr_out, instr_pc);
    end
    drive(1'b0, 12'h000, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL basic_done: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 12'h010, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, 12'h7FF, 1'b1, 16'h1234, 1'b0, 1'b0);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, imem_addr} !== {3'b101, 12'h010}) begin
      n_errors++;
      $display("FAIL stall_req: req/valid/inc=%b addr=%h expected 101 addr 010",
               {imem_req, instr_valid, pc_inc}, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'h222, 1'b0, '0, 1'b0, 1'b0);
      n_checks++;
      if ({imem_req, instr_valid, pc_inc, instr_out, instr_pc} !== {3'b010, 16'h1234, 12'h010}) begin
        n_errors++;
        $display("FAIL stall_hold%0d: req/valid/inc=%b out=%h pc=%h expected 010 1234 010",
                 i, {imem_req, instr_valid, pc_inc}, instr_out, instr_pc);
      end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL stall_done: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
  endtask

  task automatic test_redirect_req();
    drive(1'b1, 12'h020, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 12'h080, 1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, imem_addr} !== {3'b100, 12'h020}) begin
      n_errors++;
      $display("FAIL redir_req: req/valid/inc=%b addr=%h expected 100 addr 020",
               {imem_req, instr_valid, pc_inc}, imem_addr);
    end
    drive(1'b1, 12'h080, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 12'h020}) begin
      n_errors++;
      $display("FAIL redir_keep: req=%b addr=%h expected 1 addr 020", imem_req, imem_addr);
    end
    drive(1'b1, 12'h080, 1'b1, 16'h9999, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b100) begin
      n_errors++;
      $display("FAIL redir_late_ack: req/valid/inc=%b expected 100", {imem_req, instr_valid, pc_inc});
    end
    drive(1'b1, 12'h080, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL redir_idle: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
    drive(1'b0, 12'h080, 1'b1, 16'hBEEF, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, imem_addr} !== {3'b101, 12'h080}) begin
      n_errors++;
      $display("FAIL redir_refetch: req/valid/inc=%b addr=%h expected 101 addr 080",
               {imem_req, instr_valid, pc_inc}, imem_addr);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 16'hBEEF, 12'h080}) begin
      n_errors++;
      $display("FAIL redir_result: valid=%b out=%h pc=%h expected 1 beef 080", instr_valid, instr_out, instr_pc);
    end
  endtask

  task automatic test_ack_redirect();
    drive(1'b1, 12'h030, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, 12'h030, 1'b1, 16'h7777, 1'b1, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b100) begin
      n_errors++;
      $display("FAIL ackredir_inc: req/valid/inc=%b expected 100", {imem_req, instr_valid, pc_inc});
    end
    drive(1'b1, 12'h031, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, instr_out} !== {3'b000, 16'hBEEF}) begin
      n_errors++;
      $display("FAIL ackredir_idle: req/valid/inc=%b out=%h expected 000 out beef",
               {imem_req, instr_valid, pc_inc}, instr_out);
    end
    drive(1'b0, '0, 1'b1, 16'h4321, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, pc_inc, imem_addr} !== {2'b11, 12'h031}) begin
      n_errors++;
      $display("FAIL ackredir_next: req/inc=%b addr=%h expected 11 addr 031", {imem_req, pc_inc}, imem_addr);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({instr_valid, instr_out, instr_pc} !== {1'b1, 16'h4321, 12'h031}) begin
      n_errors++;
      $display("FAIL ackredir_result: valid=%b out=%h pc=%h expected 1 4321 031", instr_valid, instr_out, instr_pc);
    end
  endtask

  task automatic test_redirect_hold();
    drive(1'b1, 12'h040, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 16'h5555, 1'b0, 1'b0);
    drive(1'b1, 12'h0C0, 1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b010) begin
      n_errors++;
      $display("FAIL holdredir_cycle: req/valid/inc=%b expected 010", {imem_req, instr_valid, pc_inc});
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL holdredir_drop: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 12'h050, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_pre: req=%b expected 1", imem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, pc_inc, imem_addr} !== {3'b000, 12'h000}) begin
      n_errors++;
      $display("FAIL rstmid_now: req/valid/inc=%b addr=%h expected 000 addr 000",
               {imem_req, instr_valid, pc_inc}, imem_addr);
    end
    drive(1'b0, '0, 1'b1, 16'hDEAD, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL rstmid_ack: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, instr_out, instr_pc} !== {2'b00, 16'h0000, 12'h000}) begin
      n_errors++;
      $display("FAIL rstmid_after: req/valid=%b out=%h pc=%h expected 00 0000 000",
               {imem_req, instr_valid}, instr_out, instr_pc);
    end
  endtask

  // Zero-wait memory, always-ready consumer: one instruction every two cycles.
  task automatic test_back_to_back();
    logic [AW-1:0] pc;
    logic [AW-1:0] exp_pc;
    int incs;
    int xfers;
    pc = 12'h100; exp_pc = 12'h100; incs = 0; xfers = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      fetch_en = 1'b1; pc_in = pc; imem_ack = 1'b1; redirect = 1'b0; instr_ready = 1'b1;
      imem_rdata = {4'hC, imem_addr};
      #1;
      n_checks++;
      if (imem_req && instr_valid) begin
        n_errors++;
        $display("FAIL b2b_overlap: req and valid both high at cycle %0d", c);
      end
      if (instr_valid) begin
        xfers++;
        n_checks++;
        if ({instr_out, instr_pc} !== {4'hC, exp_pc, exp_pc}) begin
          n_errors++;
          $display("FAIL b2b_data: out=%h pc=%h expected out %h pc %h", instr_out, instr_pc, {4'hC, exp_pc}, exp_pc);
        end
        exp_pc = exp_pc + 1'b1;
      end
      if (pc_inc) begin
        incs++;
        pc = pc + 1'b1;
      end
    end
    n_checks++;
    if (incs != 10 || xfers != 9) begin
      n_errors++;
      $display("FAIL b2b_rate: pc_inc=%0d transfers=%0d expected 10 and 9", incs, xfers);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if ({imem_req, instr_valid, pc_inc} !== 3'b000) begin
      n_errors++;
      $display("FAIL b2b_drain: req/valid/inc=%b expected 000", {imem_req, instr_valid, pc_inc});
    end
  endtask

  // Reference model: at most one outstanding read (possibly poisoned by a redirect)
  // and at most one instruction waiting for the consumer.
  task automatic test_random();
    bit            m_pend;
    bit            m_poison;
    bit            m_held;
    logic [AW-1:0] m_req_addr;
    logic [IW-1:0] m_out;
    logic [AW-1:0] m_pc;
    bit            exp_inc;
    m_pend = 0; m_poison = 0; m_held = 0; m_req_addr = '0; m_out = '0; m_pc = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      fetch_en    = ($urandom_range(9) < 7);
      redirect    = ($urandom_range(19) < 3);
      imem_ack    = ($urandom_range(1) == 1);
      instr_ready = ($urandom_range(9) < 6);
      pc_in       = AW'($urandom);
      imem_rdata  = IW'($urandom);
      #1;
      exp_inc = m_pend && imem_ack && !redirect && !m_poison;
      n_checks++;
      if ({imem_req, instr_valid, pc_inc} !== {m_pend, m_held, exp_inc}) begin
        n_errors++;
        $display("FAIL rand_ctrl c%0d: req/valid/inc=%b expected %b", c,
                 {imem_req, instr_valid, pc_inc}, {m_pend, m_held, exp_inc});
      end
      if (m_pend) begin
        n_checks++;
        if (imem_addr !== m_req_addr) begin
          n_errors++;
          $display("FAIL rand_addr c%0d: addr=%h expected %h", c, imem_addr, m_req_addr);
        end
      end
      if (m_held) begin
        n_checks++;
        if ({instr_out, instr_pc} !== {m_out, m_pc}) begin
          n_errors++;
          $display("FAIL rand_instr c%0d: out=%h pc=%h expected %h %h", c, instr_out, instr_pc, m_out, m_pc);
        end
      end
      if (m_pend) begin
        if (imem_ack) begin
          if (exp_inc) begin
            m_held = 1; m_out = imem_rdata; m_pc = m_req_addr;
          end
          m_pend = 0; m_poison = 0;
        end else if (redirect) begin
          m_poison = 1;
        end
      end else if (m_held) begin
        if (redirect) begin
          m_held = 0;
        end else if (instr_ready) begin
          m_held = 0;
          if (fetch_en) begin
            m_pend = 1; m_req_addr = pc_in;
          end
        end
      end else if (fetch_en && !redirect) begin
        m_pend = 1; m_req_addr = pc_in;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_req();
    test_ack_redirect();
    test_redirect_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the instruction address width, matching the program counter width.
REQ-002 Parameter INSTR_WIDTH, default 16, SHALL set the instruction word width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 fetch_en  in  1  SHALL enable the start of new fetches.
REQ-006 pc_in  in  ADDR_WIDTH  SHALL carry the current PC from the program counter.
REQ-007 pc_inc  out  1  SHALL request a PC increment of +1, as a one-cycle pulse.
REQ-008 redirect  in  1  SHALL signal a branch or flush; the same cycle loads the PC externally.
REQ-009 imem_req  out  1  SHALL request an instruction memory read.
REQ-010 imem_addr  out  ADDR_WIDTH  SHALL carry the read address.
REQ-011 imem_ack  in  1  SHALL mark imem_rdata valid for one cycle.
REQ-012 imem_rdata  in  INSTR_WIDTH  SHALL carry the returned instruction word.
REQ-013 instr_valid  out  1  SHALL mark instr_out and instr_pc valid.
REQ-014 instr_ready  in  1  SHALL mark consumer acceptance; a transfer occurs when valid & ready.
REQ-015 instr_out  out  INSTR_WIDTH  SHALL carry the fetched instruction.
REQ-016 instr_pc  out  ADDR_WIDTH  SHALL carry the address of instr_out.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ, HOLD.
REQ-018 IDLE: if fetch_en=1 and redirect=0, SHALL latch addr_r<=pc_in and go to REQ; otherwise stay in IDLE.
REQ-019 REQ: imem_req=1 and imem_addr=addr_r; both SHALL stay stable until imem_ack.
REQ-020 REQ + imem_ack with redirect=0 and flush_pending=0: SHALL capture instr_out<=imem_rdata and instr_pc<=addr_r, assert pc_inc combinationally in that cycle, and go to HOLD.
REQ-021 REQ + redirect without imem_ack: SHALL set flush_pending and keep imem_req high (no cancel); the later ack SHALL be discarded with no pc_inc, clear flush_pending, and go to IDLE.
REQ-022 REQ + imem_ack + redirect in the same cycle: SHALL discard the data, issue no pc_inc, and go to IDLE.
REQ-023 HOLD: instr_valid=1; instr_out and instr_pc SHALL stay stable until transfer.
REQ-024 HOLD + transfer: if fetch_en=1, SHALL latch addr_r<=pc_in and go to REQ; otherwise go to IDLE.
REQ-025 HOLD + redirect: SHALL drop the instruction (no transfer, even if instr_ready=1) and go to IDLE.
REQ-026 A fetch_en deassertion in REQ SHALL NOT abort the outstanding request.
REQ-027 pc_inc SHALL pulse exactly once per accepted (non-discarded) instruction; it SHALL never pulse in a cycle where redirect=1.
REQ-028 Minimum latency, fetch_en to imem_req: 1 cycle.
REQ-029 Minimum latency, imem_ack to instr_valid: 1 cycle.
REQ-030 Back-to-back throughput SHALL be one instruction per 2 cycles with a zero-wait memory.
REQ-031 instr_valid and imem_req SHALL never be high in the same cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force state=IDLE, flush_pending=0, addr_r=0, instr_out=0, instr_pc=0, imem_req=0, instr_valid=0, pc_inc=0.
REQ-033 Reset mid-request SHALL abandon the request; a post-reset ack SHALL be ignored while in IDLE.

Verification
REQ-034 Reset, fetch_en=1, pc_in=0x000, ack next cycle with rdata=0xA5C3, ready=1 -> imem_addr=0x000, pc_inc pulses once, instr_out=0xA5C3, instr_pc=0x000.
REQ-035 instr_ready=0 for 3 cycles in HOLD -> instr_valid stays 1 and instr_out is stable; no new imem_req.
REQ-036 redirect during REQ, ack 2 cycles later -> no pc_inc, no instr_valid; next fetch uses the new pc_in=0x080.
REQ-037 ack and redirect in the same cycle -> data discarded, pc_inc=0, state=IDLE.
REQ-038 redirect in HOLD with instr_ready=1 -> no transfer, instr_valid=0 next cycle.
REQ-039 rst_n low during REQ -> imem_req=0 immediately; a following ack produces no output.
